axi_stream_mem_responder: RTL

//  Memory-side endpoint for one kernel memory port: consumes the packed {address,data} store stream
//  and the load-request stream emitted by the handshake->AXI-stream write/read adapters, and returns

---
 rtl/mem_stream_pkg.sv | 12 +
 rtl/axis_fifo2.sv | 41 ++++
 rtl/axi_stream_mem_responder.sv | 78 +++++++
 3 files changed

// File: rtl/mem_stream_pkg.sv
// mem_stream_pkg: default widths and {address,data} store-beat pack/unpack helpers, address in the MSBs
package mem_stream_pkg;
  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int REQ_W_DEF = 3;
  function automatic int st_addr_lsb(input int data_w);
    return data_w;
  endfunction
  function automatic logic [ADDR_W_DEF+DATA_W_DEF-1:0] st_pack(input logic [ADDR_W_DEF-1:0] a, input logic [DATA_W_DEF-1:0] d);
    return {a, d};
  endfunction
endpackage

// File: rtl/axis_fifo2.sv
// axis_fifo2: 2-entry valid/ready FIFO; in_ready depends only on registered occupancy
module axis_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [1:0] count_q, count_d;
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic push, pop;
  always_comb begin
    in_ready = count_q != 2'd2;
    out_valid = count_q != 2'd0;
    out_data = head_q;
    push = in_valid & in_ready;
    pop = out_valid & out_ready;
    count_d = count_q + 2'(push) - 2'(pop);
    head_d = head_q;
    tail_d = tail_q;
    if (pop) head_d = count_q == 2'd2 ? tail_q : in_data;
    if (push && count_q == 2'd0) head_d = in_data;
    if (push && count_q == 2'd1 && !pop) tail_d = in_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      count_q <= count_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end
endmodule

// File: rtl/axi_stream_mem_responder.sv
// axi_stream_mem_responder: word-array memory endpoint serving store and load-request AXI streams
module axi_stream_mem_responder
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REQ_W  = REQ_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W+DATA_W-1:0] s_axis_st_tdata,
  input  logic                     s_axis_st_tvalid,
  output logic                     s_axis_st_tready,
  input  logic                     s_axis_st_tlast,
  input  logic [REQ_W-1:0]         s_axis_req_tdata,
  input  logic                     s_axis_req_tvalid,
  output logic                     s_axis_req_tready,
  input  logic                     s_axis_req_tlast,
  output logic [DATA_W-1:0]        m_axis_pl_tdata,
  output logic                     m_axis_pl_tvalid,
  input  logic                     m_axis_pl_tready,
  output logic                     m_axis_pl_tlast,
  output logic                     st_batch_done,
  output logic [15:0]              st_count,
  output logic [15:0]              ld_count
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int LSB = st_addr_lsb(DATA_W);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] st_addr, rd_addr;
  logic [DATA_W-1:0] st_data, rd_data;
  logic st_acc, pop, fifo_in_ready, unused_req;
  logic st_batch_done_q, st_batch_done_d;
  logic [15:0] st_count_q, st_count_d, ld_count_q, ld_count_d;
  always_comb begin
    st_addr = s_axis_st_tdata[LSB +: ADDR_W];
    st_data = s_axis_st_tdata[DATA_W-1:0];
    rd_addr = s_axis_req_tdata[ADDR_W-1:0];
    unused_req = ^s_axis_req_tdata;
    st_acc = s_axis_st_tvalid & ~reset;
    // write-first: a same-cycle store to the requested word is forwarded
    rd_data = (st_acc && st_addr == rd_addr) ? st_data : mem_q[rd_addr];
    mem_d = mem_q;
    if (st_acc) mem_d[st_addr] = st_data;
    pop = m_axis_pl_tvalid & m_axis_pl_tready;
    st_batch_done_d = st_acc & s_axis_st_tlast;
    st_count_d = st_count_q + 16'(st_acc);
    ld_count_d = ld_count_q + 16'(pop);
    s_axis_st_tready = ~reset;
    s_axis_req_tready = fifo_in_ready & ~reset;
    st_batch_done = st_batch_done_q;
    st_count = st_count_q;
    ld_count = ld_count_q;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      st_batch_done_q <= 1'b0;
      st_count_q <= '0;
      ld_count_q <= '0;
    end else begin
      st_batch_done_q <= st_batch_done_d;
      st_count_q <= st_count_d;
      ld_count_q <= ld_count_d;
    end
  end
  axis_fifo2 #(.W(DATA_W+1)) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .in_data  ({s_axis_req_tlast, rd_data}),
    .in_valid (s_axis_req_tvalid & ~reset),
    .in_ready (fifo_in_ready),
    .out_data ({m_axis_pl_tlast, m_axis_pl_tdata}),
    .out_valid(m_axis_pl_tvalid),
    .out_ready(m_axis_pl_tready)
  );
endmodule
